alu_sequencer: RTL and testbench

Multi-cycle execute controller that sits between instruction issue and the shared 32-bit combinational ALU. It accepts one operation at a time over a valid/ready handshake and drives the ALU's Op/A/B/Cin inputs. It owns the architectural ZNCV flag register and supplies the stored carry as Cin. It also chains two ALU passes to execute 64-bit (wide) operations, then holds the registered result until the consumer takes it.

---
 rtl/alu_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle execute controller for a shared 32-bit ALU; define ALU_SEQ_WIDE_EN to enable two-pass 64-bit ops
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic        in_wide,
    input  logic        in_s,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_cin,
    input  logic [31:0] alu_out,
    input  logic [3:0]  alu_flags,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_data,
    output logic [3:0]  res_flags,
    output logic [3:0]  flags
);
`ifdef ALU_SEQ_WIDE_EN
    typedef enum logic [1:0] {IDLE, EXEC_LO, EXEC_HI, DONE} state_t;
    localparam int W = 64;
    logic wide_q, lo_c;
`else
    typedef enum logic [1:0] {IDLE, EXEC_LO, DONE} state_t;
    localparam int W = 32;
    logic unused;
    assign unused = ^{in_wide, in_a[63:32], in_b[63:32]};
`endif
    state_t state, state_d;
    logic [3:0]   op_q;
    logic [W-1:0] a_q, b_q;
    logic         s_q, fin;
    logic [3:0]   fin_flags;

    assign in_ready  = state == IDLE;
    assign res_valid = state == DONE;
`ifdef ALU_SEQ_WIDE_EN
    assign fin       = (state == EXEC_LO && !wide_q) || state == EXEC_HI;
    assign fin_flags = state == EXEC_HI ? {{alu_out, res_data[31:0]} == 64'd0, alu_flags[2:0]} : alu_flags;
`else
    assign fin       = state == EXEC_LO;
    assign fin_flags = alu_flags;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_d;

    // next state and state-decoded ALU drive; the ALU is parked on op 13 with zero operands when not executing
    always_comb begin
        state_d = state;
        alu_op  = 4'd13;
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        case (state)
            IDLE: state_d = in_valid ? EXEC_LO : IDLE;
            EXEC_LO: begin
                alu_op  = op_q;
                alu_a   = a_q[31:0];
                alu_b   = b_q[31:0];
                alu_cin = (op_q == 4'd1 || op_q == 4'd3) && flags[1];
`ifdef ALU_SEQ_WIDE_EN
                state_d = wide_q ? EXEC_HI : DONE;
`else
                state_d = DONE;
`endif
            end
`ifdef ALU_SEQ_WIDE_EN
            EXEC_HI: begin
                alu_op  = op_q == 4'd0 ? 4'd1 : op_q == 4'd2 ? 4'd3 : op_q;
                alu_a   = a_q[63:32];
                alu_b   = b_q[63:32];
                alu_cin = op_q <= 4'd2 && lo_c;
                state_d = DONE;
            end
`endif
            DONE:    state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // request capture, result assembly and architectural flag write on the final execute pass
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= 1'b0;
            res_data  <= '0;
            res_flags <= '0;
            flags     <= '0;
`ifdef ALU_SEQ_WIDE_EN
            wide_q    <= 1'b0;
            lo_c      <= 1'b0;
`endif
        end else begin
            if (in_valid && in_ready) begin
                op_q   <= in_op;
                a_q    <= in_a[W-1:0];
                b_q    <= in_b[W-1:0];
                s_q    <= in_s;
`ifdef ALU_SEQ_WIDE_EN
                wide_q <= in_wide && in_op <= 4'd9 && in_op != 4'd3;
`endif
            end
            if (state == EXEC_LO) res_data <= {32'd0, alu_out};
`ifdef ALU_SEQ_WIDE_EN
            if (state == EXEC_LO) lo_c <= alu_flags[1];
            if (state == EXEC_HI) res_data[63:32] <= alu_out;
`endif
            if (fin) res_flags <= fin_flags;
            if (fin && s_q) flags <= fin_flags;
        end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized scoreboard bench for alu_sequencer with a behavioural ALU and 64-bit reference model
module tb_alu_sequencer;
`ifdef ALU_SEQ_WIDE_EN
    localparam bit WIDE_EN = 1'b1;
`else
    localparam bit WIDE_EN = 1'b0;
`endif
    typedef struct {
        logic [63:0] data;
        logic [3:0]  rf;
        logic [3:0]  af;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid, in_ready, in_wide, in_s, alu_cin, res_valid, res_ready;
    logic [3:0]  in_op, alu_op, alu_flags, res_flags, flags;
    logic [63:0] in_a, in_b, res_data;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  mflags = 4'd0;
    exp_t        sb[$];
    int          tests = 0, fails = 0, cyc = 0, hs_cyc = 0, bp_mode = 0;
    logic [63:0] last_data;
    logic [3:0]  last_rf;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_wide(in_wide), .in_s(in_s), .alu_op(alu_op), .alu_a(alu_a),
        .alu_b(alu_b), .alu_cin(alu_cin), .alu_out(alu_out), .alu_flags(alu_flags),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags),
        .flags(flags)
    );

    function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic cin);
        logic [32:0] t;
        logic [31:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        t = '0;
        case (op)
            4'd0, 4'd1: begin
                t = {1'b0, a} + {1'b0, b} + {32'd0, op[0] & cin};
                c = t[32];
                v = a[31] == b[31] && t[31] != a[31];
            end
            4'd2, 4'd3: begin
                t = {1'b0, a} - {1'b0, b} - {32'd0, op[0] & cin};
                c = t[32];
                v = a[31] != b[31] && t[31] != a[31];
            end
            4'd4:  t[31:0] = a & b;
            4'd5:  t[31:0] = a | b;
            4'd6:  t[31:0] = a ^ b;
            4'd7:  t[31:0] = a & ~b;
            4'd8:  t[31:0] = ~(a | b);
            4'd9:  t[31:0] = ~(a ^ b);
            4'd10: t[31:0] = a << b[4:0];
            4'd11: t[31:0] = a >> b[4:0];
            4'd12: t[31:0] = $signed(a) >>> b[4:0];
            4'd13: t[31:0] = a;
            4'd14: t[31:0] = b;
            default: t[31:0] = ~a;
        endcase
        r = t[31:0];
        return {r == 32'd0, r[31], c, v, r};
    endfunction

    assign {alu_flags, alu_out} = alu_f(alu_op, alu_a, alu_b, alu_cin);

    function automatic logic [63:0] bitwise64(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return a & ~b;
            4'd8:    return ~(a | b);
            default: return ~(a ^ b);
        endcase
    endfunction

    // Whole-request result: 64-bit arithmetic for wide ops, a single ALU evaluation on the low words otherwise
    function automatic exp_t expect_of(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic w);
        exp_t e;
        logic [64:0] t;
        logic [63:0] r;
        logic [35:0] n;
        logic ew, c, v;
        ew = WIDE_EN && w && op <= 4'd9 && op != 4'd3;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        t = '0;
        if (ew && op <= 4'd1) begin
            t = {1'b0, a} + {1'b0, b} + {64'd0, op[0] & mflags[1]};
            r = t[63:0];
            c = t[64];
            v = a[63] == b[63] && r[63] != a[63];
        end else if (ew && op == 4'd2) begin
            r = a - b;
            c = a < b;
            v = a[63] != b[63] && r[63] != a[63];
        end else if (ew) r = bitwise64(op, a, b);
        n = alu_f(op, a[31:0], b[31:0], (op == 4'd1 || op == 4'd3) && mflags[1]);
        e.data = ew ? r : {32'd0, n[31:0]};
        e.rf   = ew ? {r == 64'd0, r[63], c, v} : n[35:32];
        e.af   = 4'd0;
        e.lat  = ew ? 3 : 2;
        e.acc  = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic w, input logic s, input logic push, output int acc);
        exp_t e;
        int t;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_wide = w;
        in_s = s;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        acc = cyc;
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", t);
        end else if (push) begin
            e = expect_of(op, a, b, w);
            if (s) mflags = e.rf;
            e.af = mflags;
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op = 4'($urandom);
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        in_wide = 1'($urandom);
        in_s = 1'($urandom);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 4))
            0:       return 64'd0;
            1:       return '1;
            2:       return {$urandom, 32'hFFFF_FFFF};
            3:       return {32'd0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // consumer: always ready, random ready, or ready only after res_valid has been up for 3 cycles
    initial begin
        int vcnt;
        vcnt = 0;
        res_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            vcnt = res_valid ? vcnt + 1 : 0;
            res_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? ($urandom_range(0, 2) != 0) : (vcnt > 3);
        end
    end

    // monitor: handshake rules, hold stability, latency and scoreboard comparison
    initial begin
        logic prev_v, prev_r, prev_hs, hs;
        logic [63:0] prev_d;
        logic [3:0] prev_f;
        exp_t e;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_hs = 1'b0;
        prev_d = '0;
        prev_f = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
                prev_hs = 1'b0;
            end else begin
                hs = res_valid && res_ready;
                if (prev_hs) chk("idle_after_handshake", 64'(in_ready), 64'd1);
                if (res_valid) chk("in_ready_while_valid", 64'(in_ready), 64'd0);
                if (res_valid && prev_v && !prev_r) begin
                    chk("hold_res_data", res_data, prev_d);
                    chk("hold_res_flags", 64'(res_flags), 64'(prev_f));
                end
                if (res_valid && !prev_v && sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_valid: res_valid=1 with no request outstanding");
                end else if (res_valid && !prev_v) chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                if (hs && sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("res_data", res_data, e.data);
                    chk("res_flags", 64'(res_flags), 64'(e.rf));
                    chk("flags", 64'(flags), 64'(e.af));
                    last_data = res_data;
                    last_rf = res_flags;
                    hs_cyc = cyc;
                end
                prev_hs = hs;
                prev_v = res_valid;
                prev_r = res_ready;
                prev_d = res_data;
                prev_f = res_flags;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2;
        in_valid = 1'b0;
        in_op = '0;
        in_a = '0;
        in_b = '0;
        in_wide = 1'b0;
        in_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", res_data, 64'd0);
        chk("rst_res_flags", 64'(res_flags), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd13);
        chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        chk("rst_alu_cin", 64'(alu_cin), 64'd0);
        rst_n = 1'b1;

        issue(4'd0, 64'h7731_5843, 64'h3153_9734, 1'b0, 1'b1, 1'b1, acc);
        wait_done();
        chk("nadd_data", last_data, 64'h0000_0000_A884_EF77);
        chk("nadd_res_flags", 64'(last_rf), 64'b0101);
        chk("nadd_flags", 64'(flags), 64'b0101);

        issue(4'd0, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b1, acc);
        wait_done();
        chk("carry_data", last_data, 64'd0);
        chk("carry_flags", 64'(flags), 64'b1010);
        issue(4'd1, 64'd5, 64'd6, 1'b0, 1'b0, 1'b1, acc);
        chk("adc_alu_op", 64'(alu_op), 64'd1);
        chk("adc_alu_cin", 64'(alu_cin), 64'd1);
        wait_done();
        chk("adc_data", last_data, 64'd12);

        issue(4'd0, 64'h0_FFFF_FFFF, 64'h0_0000_0001, 1'b1, 1'b0, 1'b1, acc);
        chk("wadd_lo_op", 64'(alu_op), 64'd0);
        chk("wadd_lo_cin", 64'(alu_cin), 64'd0);
        chk("wadd_lo_ab", {alu_a, alu_b}, {32'hFFFF_FFFF, 32'h1});
`ifdef ALU_SEQ_WIDE_EN
        @(posedge clk); #1;
        chk("wadd_hi_op", 64'(alu_op), 64'd1);
        chk("wadd_hi_cin", 64'(alu_cin), 64'd1);
`endif
        wait_done();
        chk("wadd_data", last_data, WIDE_EN ? 64'h1_0000_0000 : 64'd0);
        chk("wadd_res_flags", 64'(last_rf), WIDE_EN ? 64'b0000 : 64'b1010);

        issue(4'd2, 64'h1_0000_0000, 64'h1, 1'b1, 1'b0, 1'b1, acc);
        chk("wsub_lo_op", 64'(alu_op), 64'd2);
`ifdef ALU_SEQ_WIDE_EN
        @(posedge clk); #1;
        chk("wsub_hi_op", 64'(alu_op), 64'd3);
        chk("wsub_hi_cin", 64'(alu_cin), 64'd1);
`endif
        wait_done();
        chk("wsub_data", last_data, WIDE_EN ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF);
        chk("wsub_res_flags", 64'(last_rf), WIDE_EN ? 64'b0000 : 64'b0110);

        bp_mode = 2;
        issue(4'd6, rnd64(), rnd64(), 1'b1, 1'b1, 1'b1, acc);
        issue(4'd0, rnd64(), rnd64(), 1'b0, 1'b0, 1'b1, acc2);
        chk("bp_next_accept", 64'(acc2), 64'(hs_cyc + 1));
        wait_done();
        bp_mode = 0;

        issue(4'd0, '1, 64'd1, 1'b1, 1'b1, 1'b0, acc);
`ifdef ALU_SEQ_WIDE_EN
        @(posedge clk); #1;
        chk("abort_in_hi", 64'(alu_op), 64'd1);
`endif
        #1 rst_n = 1'b0;
        #1;
        mflags = 4'd0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_res_valid", 64'(res_valid), 64'd0);
        chk("abort_res_data", res_data, 64'd0);
        chk("abort_res_flags", 64'(res_flags), 64'd0);
        chk("abort_alu_op", 64'(alu_op), 64'd13);
        chk("abort_alu_ab", {alu_a, alu_b}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_res_valid", 64'(res_valid), 64'd0);
        chk("release_flags", 64'(flags), 64'd0);
        issue(4'd1, 64'd5, 64'd6, 1'b0, 1'b1, 1'b1, acc);
        wait_done();
        chk("post_abort_adc", last_data, 64'd11);

        bp_mode = 1;
        for (int i = 0; i < 300; i++)
            issue(4'($urandom_range(0, 15)), rnd64(), rnd64(), 1'($urandom), 1'($urandom), 1'b1, acc);
        wait_done();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
